bin2bcd_serial: RTL and testbench

BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

---
 rtl/bin2bcd_serial_if.sv | 24 ++
 rtl/bin2bcd_serial.sv | 106 ++++++++++
 tb/tb_bin2bcd_serial.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_serial_if.sv
// Operand/result handshake bundle for the serial binary-to-BCD converter.
// The master drives the operand and consumes the result; the slave is the converter.
interface bin2bcd_serial_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) ();
  logic                  in_valid;
  logic [WIDTH-1:0]      bin;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, ovf
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, ovf
  );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one bit per clock, fixed WIDTH-cycle latency,
// result held until consumed, sticky overflow when the value needs more than DIGITS digits.
module bin2bcd_serial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bin2bcd_serial_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] sh_q;
  logic [AW-1:0]    acc_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             step;
  logic [AW-1:0]    acc_adj;
  logic [AW-1:0]    acc_next;

  // Add-3 correction on every digit before the shift; 4-bit wrap is intended.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign acc_next = {acc_adj[AW-2:0], sh_q[WIDTH-1]};

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Leaving DONE always lands in IDLE, which forces the one-cycle bubble before the next accept.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      sh_q  <= bus.bin;
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= CW'(WIDTH);
    end else if (step) begin
      sh_q  <= sh_q << 1;
      acc_q <= acc_next;
      ovf_q <= ovf_q | acc_adj[AW-1];
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bcd       = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial: a 3-digit and a 2-digit instance run in lockstep on the
// same stimulus; expected results are queued at accept and compared when out_valid appears.
module tb_bin2bcd_serial;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bin2bcd_serial_if #(.WIDTH(8), .DIGITS(3)) bus  ();
  bin2bcd_serial_if #(.WIDTH(8), .DIGITS(2)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.bin       = bus.bin;
  assign bus2.out_ready = bus.out_ready;

  bin2bcd_serial #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  bin2bcd_serial #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
    logic [7:0]  bcd2;
    logic        ovf2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic push(input int v);
    exp_t        e;
    logic [11:0] full;
    full   = to_bcd(v);
    e.bcd  = full;
    e.ovf  = 1'b0;
    e.bcd2 = full[7:0];
    e.ovf2 = (v > 99);
    sb.push_back(e);
  endtask

  // Presents v and waits (bounded) for in_ready; returns edges spent waiting before the accept edge.
  task automatic do_accept(input int v, output int waited);
    bus.bin      = 8'(v);
    bus.in_valid = 1'b1;
    waited       = 0;
    while (!bus.in_ready && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    push(v);
    check("busy_in_ready", bus.in_ready, 0);
  endtask

  // Counts edges since the accept until out_valid, then scores the result against the queue head.
  task automatic wait_done(input string tag, input int elapsed);
    int   lat;
    exp_t e;
    lat = elapsed;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_bcd"},  bus.bcd,   e.bcd);
      check({tag, "_ovf"},  bus.ovf,   e.ovf);
      check({tag, "_ovf2"}, bus2.ovf,  e.ovf2);
      if (!e.ovf2) check({tag, "_bcd2"}, bus2.bcd, e.bcd2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus.in_valid  = 1'b0;
    bus.bin       = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    #2;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_bcd",       bus.bcd,       0);
    check("rst_ovf",       bus.ovf,       0);
    check("rst_ovf2",      bus2.ovf,      0);
    #10 rst_n = 1'b1;

    // 255 on the first edge after reset release.
    do_accept(255, w);
    check("first_accept_wait", w, 0);
    wait_done("r255", 0);
    @(posedge clk); #1;
    check("r255_back_idle", bus.in_ready,  1);
    check("r255_ov_low",    bus.out_valid, 0);
    check("r255_retained",  bus.bcd,       12'h255);

    // Back-to-back 0, 1, 99 with in_valid already high while DONE.
    do_accept(0, w);
    wait_done("r0", 0);
    do_accept(1, w);
    check("bubble_after_0", w, 1);
    wait_done("r1", 0);
    do_accept(99, w);
    check("bubble_after_1", w, 1);
    wait_done("r99", 0);
    @(posedge clk); #1;

    // 128 held in DONE for 20 cycles with operand noise.
    bus.out_ready = 1'b0;
    do_accept(128, w);
    wait_done("r128", 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_bcd",       bus.bcd,       12'h128);
      bus.bin      = 8'($urandom);
      bus.in_valid = i[0];
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_idle",     bus.in_ready,  1);
    check("release_ov_low",   bus.out_valid, 0);
    check("release_retained", bus.bcd,       12'h128);

    // 200 with a second operand pulsed mid-conversion; 2-digit instance overflows.
    do_accept(200, w);
    bus.bin      = 8'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_done("r200", 2);
    do_accept(42, w);
    check("no_capture_of_7", w, 1);
    wait_done("r42", 0);
    @(posedge clk); #1;

    // Reset in the middle of converting 255.
    do_accept(255, w);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  bus.in_ready,  1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_bcd",       bus.bcd,       0);
    check("midrst_ovf",       bus.ovf,       0);
    check("midrst_ovf2",      bus2.ovf,      0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", bus.out_valid, 0);
    end
    do_accept(37, w);
    check("post_rst_accept_wait", w, 0);
    wait_done("r37", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
